// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: reset/bubble constants, opcodes used
// by Control, and the fetch tracker state type.
package mips_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ORI    = 6'h0d;

    typedef enum logic {
        RUN,
        WAIT
    } fetchState_t;

endpackage

// File: rtl/program_counter.sv
// Fetch PC register with +4 adder and redirect/hold selection.
// Ports: clk, reset, hold, loadEn, loadPc -> pc, pcPlus4.
module program_counter #(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        loadEn,
    input  logic [31:0] loadPc,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4
);

    // Wraps naturally at 32 bits.
    assign pcPlus4 = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (loadEn) begin
            // Redirect targets are word aligned; low bits dropped.
            pc <= loadPc & ~32'h3;
        end else if (!hold) begin
            pc <= pcPlus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID register; stall, redirect/flush, imem wait.
// Ports: clk, reset, stall, redirect_en/pc, imem_*, pc_if, IF/ID outputs,
// opcode_id; stall/bubble/redirect_cnt only with FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int PERF_CNT_WIDTH = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_if,
    output logic [31:0] instr_id,
    output logic [31:0] pc_plus4_id,
    output logic        valid_id,
    output logic [5:0]  opcode_id
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] stall_cnt,
    output logic [PERF_CNT_WIDTH-1:0] bubble_cnt,
    output logic [PERF_CNT_WIDTH-1:0] redirect_cnt
`endif
);

    import mips_pkg::*;

    logic [31:0] pcPlus4;
    logic        pcHold;

    // PC advances only on a normal cycle; redirect is handled by loadEn.
    assign pcHold = stall | ~imem_ready;

    program_counter #(
        .RESET_PC(RESET_PC)
    ) uPc (
        .clk    (clk),
        .reset  (reset),
        .hold   (pcHold),
        .loadEn (redirect_en),
        .loadPc (redirect_pc),
        .pc     (pc_if),
        .pcPlus4(pcPlus4)
    );

    assign imem_addr = pc_if;
    assign opcode_id = instr_id[31:26];

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_id    <= NOP_INSTR;
            pc_plus4_id <= 32'd0;
            valid_id    <= 1'b0;
        end else if (redirect_en) begin
            instr_id    <= NOP_INSTR;
            pc_plus4_id <= 32'd0;
            valid_id    <= 1'b0;
        end else if (stall) begin
            instr_id    <= instr_id;
            pc_plus4_id <= pc_plus4_id;
            valid_id    <= valid_id;
        end else if (!imem_ready) begin
            instr_id    <= NOP_INSTR;
            pc_plus4_id <= 32'd0;
            valid_id    <= 1'b0;
        end else begin
            instr_id    <= imem_rdata;
            pc_plus4_id <= pcPlus4;
            valid_id    <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    localparam logic [PERF_CNT_WIDTH-1:0] CNT_MAX = '1;

    fetchState_t fetchState;

    // Tracker and saturating event counters, same priority as datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchState   <= RUN;
            stall_cnt    <= '0;
            bubble_cnt   <= '0;
            redirect_cnt <= '0;
        end else begin
            if (redirect_en) begin
                if (redirect_cnt != CNT_MAX) redirect_cnt <= redirect_cnt + 1'b1;
            end else if (stall) begin
                if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
            end else if (!imem_ready) begin
                if (bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + 1'b1;
            end

            case (fetchState)
                RUN: begin
                    if (!redirect_en && !stall && !imem_ready)
                        fetchState <= WAIT;
                end
                WAIT: begin
                    if (redirect_en || imem_ready)
                        fetchState <= RUN;
                end
                default: fetchState <= RUN;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed steps then random traffic
// compared against a behavioural reference of the fetch rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stl;
    logic        rdn;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        rdy;
    logic [31:0] pcIf;
    logic [31:0] instrId;
    logic [31:0] p4Id;
    logic        validId;
    logic [5:0]  opId;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] sCnt;
    logic [15:0] bCnt;
    logic [15:0] rCnt;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic [31:0] mP4;
    logic        mValid;
    int          mS;
    int          mB;
    int          mR;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk        (clk),
        .reset      (rst),
        .stall      (stl),
        .redirect_en(rdn),
        .redirect_pc(rpc),
        .imem_addr  (addr),
        .imem_rdata (rdata),
        .imem_ready (rdy),
        .pc_if      (pcIf),
        .instr_id   (instrId),
        .pc_plus4_id(p4Id),
        .valid_id   (validId),
        .opcode_id  (opId)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt   (sCnt),
        .bubble_cnt  (bCnt),
        .redirect_cnt(rCnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Reference: one clock edge with the currently driven inputs.
    task automatic modelStep();
        if (rst) begin
            mPc = 32'h0040_0000;
            mInstr = 32'h0; mP4 = 32'h0; mValid = 1'b0;
            mS = 0; mB = 0; mR = 0;
        end else if (rdn) begin
            mPc = {rpc[31:2], 2'b00};
            mInstr = 32'h0; mP4 = 32'h0; mValid = 1'b0;
            mR = sat(mR);
        end else if (stl) begin
            mS = sat(mS);
        end else if (!rdy) begin
            mInstr = 32'h0; mValid = 1'b0;
            mB = sat(mB);
        end else begin
            mInstr = rdata;
            mP4 = mPc + 32'd4;
            mPc = mPc + 32'd4;
            mValid = 1'b1;
        end
    endtask

    task automatic checkAll(input string tag);
        chk({tag, ".pc"}, pcIf, mPc);
        chk({tag, ".addr"}, addr, mPc);
        chk({tag, ".instr"}, instrId, mInstr);
        chk({tag, ".valid"}, {31'b0, validId}, {31'b0, mValid});
        chk({tag, ".op"}, {26'b0, opId}, {26'b0, mInstr[31:26]});
        if (mValid) chk({tag, ".p4"}, p4Id, mP4);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".scnt"}, {16'b0, sCnt}, mS);
        chk({tag, ".bcnt"}, {16'b0, bCnt}, mB);
        chk({tag, ".rcnt"}, {16'b0, rCnt}, mR);
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        modelStep();
        #1;
        checkAll(tag);
    endtask

    task automatic drive(input logic r, input logic s, input logic d,
                         input logic [31:0] p, input logic y,
                         input logic [31:0] w);
        rst = r; stl = s; rdn = d; rpc = p; rdy = y; rdata = w;
    endtask

    initial begin
        mPc = 32'h0; mInstr = 32'h0; mP4 = 32'h0; mValid = 1'b0;
        mS = 0; mB = 0; mR = 0;
        drive(1, 0, 0, 0, 1, 0);
        @(negedge clk);
        tick("reset");
        chk("reset.pcConst", pcIf, 32'h0040_0000);
        chk("reset.validConst", {31'b0, validId}, 32'h0);

        drive(0, 0, 0, 0, 1, 32'h2008_0005);
        tick("n1");
        chk("n1.pcConst", pcIf, 32'h0040_0004);
        chk("n1.opConst", {26'b0, opId}, 32'h08);
        drive(0, 0, 0, 0, 1, 32'h3529_00FF);
        tick("n2");
        chk("n2.pcConst", pcIf, 32'h0040_0008);
        chk("n2.opConst", {26'b0, opId}, 32'h0D);

        drive(0, 1, 0, 0, 1, 32'hDEAD_BEEF);
        tick("stall1");
        tick("stall2");
        chk("stall.pcConst", pcIf, 32'h0040_0008);
        chk("stall.instrConst", instrId, 32'h3529_00FF);

        drive(0, 0, 0, 0, 1, 32'h0109_5020);
        tick("n3");
        chk("n3.pcConst", pcIf, 32'h0040_000C);
        chk("n3.opConst", {26'b0, opId}, 32'h00);
        chk("n3.validConst", {31'b0, validId}, 32'h1);

        drive(0, 1, 1, 32'h0040_0043, 1, 32'h1234_5678);
        tick("redirStall");
        chk("redir.pcConst", pcIf, 32'h0040_0040);
        chk("redir.instrConst", instrId, 32'h0);

        drive(0, 0, 1, 32'h0040_0011, 0, 32'h0);
        tick("redir2");
        drive(0, 0, 0, 0, 0, 32'hFFFF_0000);
        tick("wait1");
        tick("wait2");
        tick("wait3");
        chk("wait.pcConst", pcIf, 32'h0040_0010);
        drive(0, 0, 0, 0, 1, 32'h2008_0007);
        tick("waitDone");
        chk("waitDone.instrConst", instrId, 32'h2008_0007);
        chk("waitDone.p4Const", p4Id, 32'h0040_0014);

        drive(0, 0, 1, 32'hFFFF_FFFF, 1, 32'h0);
        tick("toTop");
        drive(0, 0, 0, 0, 1, 32'h3400_0001);
        tick("wrap");
        chk("wrap.pcConst", pcIf, 32'h0);
        chk("wrap.p4Const", p4Id, 32'h0);

        drive(0, 0, 0, 0, 0, 32'h0);
        tick("preRstWait");
        drive(1, 1, 0, 0, 0, 32'h0);
        tick("rstInWait");
        chk("rstInWait.pcConst", pcIf, 32'h0040_0000);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0),
                  $urandom(),
                  ($urandom_range(0, 3) != 0),
                  $urandom());
            tick("rand");
        end

`ifdef FETCH_PERF_CNT_EN
        drive(1, 0, 0, 0, 1, 32'h0);
        tick("satRst");
        drive(0, 1, 0, 0, 1, 32'h0);
        repeat (65541) begin
            @(posedge clk);
            modelStep();
        end
        #1;
        checkAll("sat");
        chk("sat.scntConst", {16'b0, sCnt}, 32'h0000_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
